// File: rtl/ps2_key_tracker_if.sv
// Bundles the raw PS/2 lines and the decoded key outputs of ps2_key_tracker.
// master = the tracker itself; slave = the keyboard/consumer side.
interface ps2_key_tracker_if;
  logic       ps2_clk;
  logic       ps2_data;
  logic       key_up;
  logic       key_down;
  logic       key_left;
  logic       key_right;
  logic       key_shoot;
  logic       key_bomb;
  logic       key_enter;
  logic       enter_pulse;
  logic       bomb_pulse;
  logic [7:0] last_code;
  logic       code_valid;
  logic       frame_err;

  modport master (
    input  ps2_clk, ps2_data,
    output key_up, key_down, key_left, key_right, key_shoot, key_bomb, key_enter,
    output enter_pulse, bomb_pulse, last_code, code_valid, frame_err
  );

  modport slave (
    output ps2_clk, ps2_data,
    input  key_up, key_down, key_left, key_right, key_shoot, key_bomb, key_enter,
    input  enter_pulse, bomb_pulse, last_code, code_valid, frame_err
  );
endinterface

// File: rtl/ps2_key_tracker.sv
// PS/2 receiver + make/break/extended decoder tracking held game keys.
// Byte out one cycle after the stop-bit edge, held keys one cycle later; no backpressure.
module ps2_key_tracker #(
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic              clk,
  input  logic              rst,
  ps2_key_tracker_if.master bus
);

  localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  // key vector bit order: up, down, left, right, shoot, bomb, enter
  localparam int K_UP    = 0;
  localparam int K_DOWN  = 1;
  localparam int K_LEFT  = 2;
  localparam int K_RIGHT = 3;
  localparam int K_SHOOT = 4;
  localparam int K_BOMB  = 5;
  localparam int K_ENTER = 6;

  logic          r_clk_s1;
  logic          r_clk_s2;
  logic          r_dat_s1;
  logic          r_dat_s2;
  logic          r_clk_flt;
  logic          r_clk_flt_d;
  logic [FW-1:0] r_flt_cnt;
  logic          w_fe;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [2:0]    r_bit_cnt;
  logic [7:0]    r_shift;
  logic          r_par_ok;
  logic [TW-1:0] r_to_cnt;
  logic          w_timeout;
  logic          w_frame_good;
  logic          w_frame_bad;

  logic [7:0]    r_last_code;
  logic          r_code_valid;
  logic          r_frame_err;

  logic          r_ext;
  logic          r_brk;
  logic [6:0]    r_keys;
  logic          r_enter_pulse;
  logic          r_bomb_pulse;
  logic [6:0]    w_hit;
  logic          w_is_f0;
  logic          w_is_e0;

  // Lines idle high, so the synchronizers and filter reset to 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_clk_s1 <= 1'b1;
      r_clk_s2 <= 1'b1;
      r_dat_s1 <= 1'b1;
      r_dat_s2 <= 1'b1;
    end else begin
      r_clk_s1 <= bus.ps2_clk;
      r_clk_s2 <= r_clk_s1;
      r_dat_s1 <= bus.ps2_data;
      r_dat_s2 <= r_dat_s1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_clk_flt   <= 1'b1;
      r_clk_flt_d <= 1'b1;
      r_flt_cnt   <= '0;
    end else begin
      r_clk_flt_d <= r_clk_flt;
      if (r_clk_s2 == r_clk_flt) begin
        r_flt_cnt <= '0;
      end else if (r_flt_cnt == FW'(FILTER_LEN - 1)) begin
        r_clk_flt <= r_clk_s2;
        r_flt_cnt <= '0;
      end else begin
        r_flt_cnt <= r_flt_cnt + 1'b1;
      end
    end
  end

  assign w_fe = r_clk_flt_d & ~r_clk_flt;

  assign w_timeout = (r_state != S_IDLE) && !w_fe &&
                     (r_to_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_frame_good = 1'b0;
    w_frame_bad  = 1'b0;
    if (w_timeout) begin
      w_state_nxt = S_IDLE;
      w_frame_bad = 1'b1;
    end else if (w_fe) begin
      case (r_state)
        S_IDLE: begin
          if (!r_dat_s2) begin
            w_state_nxt = S_DATA;
          end
        end
        S_DATA: begin
          if (r_bit_cnt == 3'd7) begin
            w_state_nxt = S_PARITY;
          end
        end
        S_PARITY: begin
          w_state_nxt = S_STOP;
        end
        S_STOP: begin
          w_state_nxt = S_IDLE;
          if (r_dat_s2 && r_par_ok) begin
            w_frame_good = 1'b1;
          end else begin
            w_frame_bad = 1'b1;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_bit_cnt    <= '0;
      r_shift      <= '0;
      r_par_ok     <= 1'b0;
      r_to_cnt     <= '0;
      r_last_code  <= '0;
      r_code_valid <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      if (r_state == S_IDLE || w_fe || w_timeout) begin
        r_to_cnt <= '0;
      end else begin
        r_to_cnt <= r_to_cnt + 1'b1;
      end

      if (w_fe && !w_timeout) begin
        case (r_state)
          S_IDLE: begin
            r_bit_cnt <= '0;
          end
          S_DATA: begin
            r_shift   <= {r_dat_s2, r_shift[7:1]};
            r_bit_cnt <= r_bit_cnt + 3'd1;
          end
          S_PARITY: begin
            r_par_ok <= ^{r_shift, r_dat_s2};
          end
          default: begin
          end
        endcase
      end

      r_code_valid <= w_frame_good;
      r_frame_err  <= w_frame_bad;
      if (w_frame_good) begin
        r_last_code <= r_shift;
      end
    end
  end

  assign w_is_f0 = (r_last_code == 8'hF0);
  assign w_is_e0 = (r_last_code == 8'hE0);

  // Unprefixed arrow codes (keypad) fall through to no hit.
  always_comb begin
    w_hit = '0;
    if (r_ext) begin
      case (r_last_code)
        8'h75:   w_hit[K_UP]    = 1'b1;
        8'h72:   w_hit[K_DOWN]  = 1'b1;
        8'h6B:   w_hit[K_LEFT]  = 1'b1;
        8'h74:   w_hit[K_RIGHT] = 1'b1;
        default: w_hit = '0;
      endcase
    end else begin
      case (r_last_code)
        8'h1D:   w_hit[K_UP]    = 1'b1;
        8'h1B:   w_hit[K_DOWN]  = 1'b1;
        8'h1C:   w_hit[K_LEFT]  = 1'b1;
        8'h23:   w_hit[K_RIGHT] = 1'b1;
        8'h1A:   w_hit[K_SHOOT] = 1'b1;
        8'h22:   w_hit[K_BOMB]  = 1'b1;
        8'h5A:   w_hit[K_ENTER] = 1'b1;
        default: w_hit = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ext         <= 1'b0;
      r_brk         <= 1'b0;
      r_keys        <= '0;
      r_enter_pulse <= 1'b0;
      r_bomb_pulse  <= 1'b0;
    end else begin
      r_enter_pulse <= 1'b0;
      r_bomb_pulse  <= 1'b0;
      if (r_code_valid) begin
        if (w_is_f0) begin
          r_brk <= 1'b1;
        end else if (w_is_e0) begin
          r_ext <= 1'b1;
        end else begin
          r_brk <= 1'b0;
          r_ext <= 1'b0;
          if (r_brk) begin
            r_keys <= r_keys & ~w_hit;
          end else begin
            r_keys        <= r_keys | w_hit;
            r_enter_pulse <= w_hit[K_ENTER] & ~r_keys[K_ENTER];
            r_bomb_pulse  <= w_hit[K_BOMB] & ~r_keys[K_BOMB];
          end
        end
      end
    end
  end

  assign bus.key_up      = r_keys[K_UP];
  assign bus.key_down    = r_keys[K_DOWN];
  assign bus.key_left    = r_keys[K_LEFT];
  assign bus.key_right   = r_keys[K_RIGHT];
  assign bus.key_shoot   = r_keys[K_SHOOT];
  assign bus.key_bomb    = r_keys[K_BOMB];
  assign bus.key_enter   = r_keys[K_ENTER];
  assign bus.enter_pulse = r_enter_pulse;
  assign bus.bomb_pulse  = r_bomb_pulse;
  assign bus.last_code   = r_last_code;
  assign bus.code_valid  = r_code_valid;
  assign bus.frame_err   = r_frame_err;

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Directed + randomized bench for ps2_key_tracker against a table-driven key model.
module tb_ps2_key_tracker;
  localparam int HALF = 20;
  localparam int TO   = 300;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ps2_key_tracker_if u_if ();

  ps2_key_tracker #(
    .FILTER_LEN    (4),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(u_if.master)
  );

  int checks = 0;
  int errors = 0;

  logic [6:0] m_keys;
  logic       m_ext;
  logic       m_brk;
  logic [7:0] m_last;
  int         keymap[int];
  int         n_enter_p = 0;
  int         n_bomb_p  = 0;
  int         exp_enter_p = 0;
  int         exp_bomb_p  = 0;

  logic [6:0] keys_obs;
  assign keys_obs = {u_if.key_enter, u_if.key_bomb, u_if.key_shoot, u_if.key_right,
                     u_if.key_left, u_if.key_down, u_if.key_up};

  always @(negedge clk) begin
    if (u_if.enter_pulse === 1'b1) n_enter_p++;
    if (u_if.bomb_pulse === 1'b1) n_bomb_p++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: each byte is looked up as {ext, code} in a key table.
  task automatic model_byte(input logic [7:0] b);
    int k;
    if (b == 8'hF0) m_brk = 1'b1;
    else if (b == 8'hE0) m_ext = 1'b1;
    else begin
      k = int'({m_ext, b});
      if (keymap.exists(k)) m_keys[keymap[k]] = !m_brk;
      m_ext = 1'b0;
      m_brk = 1'b0;
    end
  endtask

  task automatic ps2_bit(input logic b);
    u_if.ps2_data = b;
    repeat (HALF) @(negedge clk);
    u_if.ps2_clk = 1'b0;
    repeat (HALF) @(negedge clk);
    u_if.ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] code, input logic bad_par, input logic bad_stop);
    logic       par;
    logic       good;
    logic       seen;
    logic       exp_ep;
    logic       exp_bp;
    logic [6:0] old_keys;
    logic [6:0] new_keys;
    int         used;
    par  = ~(^code) ^ bad_par;
    good = !bad_par && !bad_stop;
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(code[i]);
    ps2_bit(par);
    u_if.ps2_data = ~bad_stop;
    repeat (HALF) @(negedge clk);
    u_if.ps2_clk = 1'b0;
    old_keys = m_keys;
    if (good) model_byte(code);
    new_keys = m_keys;
    exp_ep = !old_keys[6] && new_keys[6];
    exp_bp = !old_keys[5] && new_keys[5];
    seen = 1'b0;
    used = 0;
    for (int c = 0; c < HALF && !seen; c++) begin
      @(negedge clk);
      used++;
      if (u_if.code_valid === 1'b1 || u_if.frame_err === 1'b1) seen = 1'b1;
    end
    check("frame_seen", seen, 1'b1);
    if (seen) begin
      check("code_valid", u_if.code_valid, good);
      check("frame_err", u_if.frame_err, !good);
      if (good) m_last = code;
      check("last_code", u_if.last_code, m_last);
      check("keys_before", keys_obs, old_keys);
      @(negedge clk);
      used++;
      check("code_valid_width", u_if.code_valid, 1'b0);
      check("frame_err_width", u_if.frame_err, 1'b0);
      check("keys_after", keys_obs, new_keys);
      check("enter_pulse", u_if.enter_pulse, exp_ep);
      check("bomb_pulse", u_if.bomb_pulse, exp_bp);
      exp_enter_p += int'(exp_ep);
      exp_bomb_p  += int'(exp_bp);
    end
    repeat (2 * HALF - used) @(negedge clk);
    u_if.ps2_clk = 1'b1;
    u_if.ps2_data = 1'b1;
    repeat (HALF) @(negedge clk);
  endtask

  initial begin
    logic [7:0] pool[16];
    logic       seen;
    logic       bp;
    logic       bs;
    pool = '{8'h1D, 8'h1B, 8'h1C, 8'h23, 8'h1A, 8'h22, 8'h5A, 8'h75,
             8'h72, 8'h6B, 8'h74, 8'hE0, 8'hF0, 8'hF0, 8'hE0, 8'h15};
    keymap['h01D] = 0; keymap['h01B] = 1; keymap['h01C] = 2; keymap['h023] = 3;
    keymap['h01A] = 4; keymap['h022] = 5; keymap['h05A] = 6;
    keymap['h175] = 0; keymap['h172] = 1; keymap['h16B] = 2; keymap['h174] = 3;
    m_keys = '0; m_ext = 1'b0; m_brk = 1'b0; m_last = 8'h00;

    u_if.ps2_clk  = 1'b1;
    u_if.ps2_data = 1'b1;
    rst = 1'b1;
    repeat (5) @(negedge clk);
    check("rst_keys", keys_obs, 7'h00);
    check("rst_last_code", u_if.last_code, 8'h00);
    check("rst_code_valid", u_if.code_valid, 1'b0);
    check("rst_frame_err", u_if.frame_err, 1'b0);
    check("rst_pulses", {u_if.enter_pulse, u_if.bomb_pulse}, 2'b00);
    rst = 1'b0;
    repeat (10) @(negedge clk);

    send_frame(8'h1D, 1'b0, 1'b0);
    check("t1_key_up", u_if.key_up, 1'b1);

    send_frame(8'h5A, 1'b0, 1'b0);
    send_frame(8'h5A, 1'b0, 1'b0);
    send_frame(8'h5A, 1'b0, 1'b0);
    check("t2_enter_held", u_if.key_enter, 1'b1);
    send_frame(8'hF0, 1'b0, 1'b0);
    check("t2_enter_still_held", u_if.key_enter, 1'b1);
    send_frame(8'h5A, 1'b0, 1'b0);
    check("t2_enter_pulses", n_enter_p, 1);
    check("t2_enter_released", u_if.key_enter, 1'b0);

    send_frame(8'hE0, 1'b0, 1'b0);
    send_frame(8'h74, 1'b0, 1'b0);
    send_frame(8'hF0, 1'b0, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b0);
    check("t3_right_left", {u_if.key_right, u_if.key_left}, 2'b10);
    send_frame(8'hE0, 1'b0, 1'b0);
    send_frame(8'hF0, 1'b0, 1'b0);
    send_frame(8'h74, 1'b0, 1'b0);
    check("t3_right_off", u_if.key_right, 1'b0);

    send_frame(8'h22, 1'b1, 1'b0);
    check("t4_bomb", {u_if.key_bomb, u_if.bomb_pulse}, 2'b00);
    send_frame(8'h1B, 1'b0, 1'b1);

    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(1'b1);
    seen = 1'b0;
    for (int c = 0; c < TO + 4 * HALF && !seen; c++) begin
      @(negedge clk);
      if (u_if.frame_err === 1'b1) seen = 1'b1;
    end
    check("t5_timeout_err", seen, 1'b1);
    check("t5_timeout_cv", u_if.code_valid, 1'b0);
    @(negedge clk);
    check("t5_timeout_err_width", u_if.frame_err, 1'b0);
    check("t5_timeout_keys", keys_obs, m_keys);
    check("t5_timeout_last", u_if.last_code, m_last);
    repeat (HALF) @(negedge clk);
    send_frame(8'h1A, 1'b0, 1'b0);
    check("t5_shoot", u_if.key_shoot, 1'b1);

    send_frame(8'h1D, 1'b0, 1'b0);
    send_frame(8'h23, 1'b0, 1'b0);
    ps2_bit(1'b0);
    for (int i = 0; i < 5; i++) ps2_bit(1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_keys = '0; m_ext = 1'b0; m_brk = 1'b0; m_last = 8'h00;
    check("t6_rst_keys", keys_obs, 7'h00);
    check("t6_rst_misc", {u_if.last_code, u_if.code_valid, u_if.frame_err,
                          u_if.enter_pulse, u_if.bomb_pulse}, 12'h000);
    u_if.ps2_data = 1'b1;
    repeat (2 * HALF) @(negedge clk);
    send_frame(8'h1B, 1'b0, 1'b0);
    check("t6_down_only", keys_obs, 7'b0000010);

    for (int n = 0; n < 40; n++) begin
      bp = ($urandom_range(0, 9) == 0);
      bs = !bp && ($urandom_range(0, 14) == 0);
      send_frame(pool[$urandom_range(0, 15)], bp, bs);
      repeat ($urandom_range(0, 40)) @(negedge clk);
    end

    repeat (5) @(negedge clk);
    check("total_enter_pulses", n_enter_p, exp_enter_p);
    check("total_bomb_pulses", n_bomb_p, exp_bomb_p);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
